// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit Harvard core: widths, opcodes and
// the writeback FSM state type. The decoder and ALU result mux use it too.
package isa_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_MOV0      = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD       = 6'b000001;
  localparam logic [OP_W-1:0] OP_SUB       = 6'b000010;
  localparam logic [OP_W-1:0] OP_STORE     = 6'b000011;
  localparam logic [OP_W-1:0] OP_AND       = 6'b000100;
  localparam logic [OP_W-1:0] OP_OR        = 6'b000101;
  localparam logic [OP_W-1:0] OP_XOR       = 6'b000110;
  localparam logic [OP_W-1:0] OP_MUL       = 6'b000111;
  localparam logic [OP_W-1:0] OP_NOT       = 6'b001000;
  localparam logic [OP_W-1:0] OP_LSH       = 6'b001001;
  localparam logic [OP_W-1:0] OP_RSH       = 6'b001010;
  localparam logic [OP_W-1:0] OP_LRSH      = 6'b010000;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 6'b010000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } wb_state_t;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for the writeback input buffer. Head entry is
// visible combinationally from storage; push on full / pop on empty ignored.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;
  assign head     = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: buffers ALU results and retires them through the single
// register-file write port, splitting MUL results into two writes.
//
// state  | meaning
// S_IDLE | no write on rf_* this cycle
// S_LO   | low-half (MUL) or single write presented on rf_*
// S_HI   | MUL high-half write presented on rf_*
module alu_writeback
  import isa_pkg::*;
#(
  parameter int DATA_W     = isa_pkg::DATA_W,
  parameter int ADDR_W     = isa_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_opcode,
  input  logic [ADDR_W-1:0]   in_rdst1,
  input  logic [ADDR_W-1:0]   in_rdst2,
  input  logic [2*DATA_W-1:0] in_result,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                retire,
  output logic                illegal_op,
  output logic                busy
);

  localparam int ENTRY_W = 6 + 2*ADDR_W + 2*DATA_W;

  wb_state_t                      state, state_n;
  logic                           cur_mul, cur_mul_n;
  logic [ADDR_W-1:0]              hi_addr, hi_addr_n;
  logic [DATA_W-1:0]              hi_data, hi_data_n;
  logic                           we_n, retire_n, illegal_n;
  logic [ADDR_W-1:0]              waddr_n;
  logic [DATA_W-1:0]              wdata_n;

  logic                           fifo_push;
  logic                           fifo_pop;
  logic [ENTRY_W-1:0]             fifo_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                           fifo_full;
  logic                           fifo_empty;

  logic [5:0]                     h_op;
  logic [ADDR_W-1:0]              h_rdst1;
  logic [ADDR_W-1:0]              h_rdst2;
  logic [2*DATA_W-1:0]            h_res;

  // in_ready and busy derive only from flops, so there is no input-to-output path.
  assign in_ready  = ~fifo_full;
  assign busy      = (state != S_IDLE) | (fifo_count != '0);
  assign fifo_push = in_valid & in_ready;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({in_opcode, in_rdst1, in_rdst2, in_result}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign h_op    = fifo_head[ENTRY_W-1 -: 6];
  assign h_rdst1 = fifo_head[2*ADDR_W+2*DATA_W-1 -: ADDR_W];
  assign h_rdst2 = fifo_head[ADDR_W+2*DATA_W-1 -: ADDR_W];
  assign h_res   = fifo_head[2*DATA_W-1:0];

  always_comb begin
    state_n   = S_IDLE;
    fifo_pop  = 1'b0;
    we_n      = 1'b0;
    waddr_n   = '0;
    wdata_n   = '0;
    retire_n  = 1'b0;
    illegal_n = 1'b0;
    cur_mul_n = 1'b0;
    hi_addr_n = hi_addr;
    hi_data_n = hi_data;

    if (state == S_LO && cur_mul) begin
      state_n  = S_HI;
      we_n     = 1'b1;
      waddr_n  = hi_addr;
      wdata_n  = hi_data;
      retire_n = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if (op_is_illegal(h_op)) begin
        retire_n  = 1'b1;
        illegal_n = 1'b1;
      end else if (h_op == OP_STORE) begin
        retire_n = 1'b1;
      end else begin
        state_n   = S_LO;
        we_n      = 1'b1;
        waddr_n   = h_rdst1;
        wdata_n   = h_res[DATA_W-1:0];
        cur_mul_n = (h_op == OP_MUL);
        retire_n  = (h_op != OP_MUL);
        hi_addr_n = h_rdst2;
        hi_data_n = h_res[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_mul    <= 1'b0;
      hi_addr    <= '0;
      hi_data    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      retire     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_n;
      cur_mul    <= cur_mul_n;
      hi_addr    <= hi_addr_n;
      hi_data    <= hi_data_n;
      rf_we      <= we_n;
      rf_waddr   <= waddr_n;
      rf_wdata   <= wdata_n;
      retire     <= retire_n;
      illegal_op <= illegal_n;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback: one task per scenario,
// outputs sampled 1 ns after each rising edge.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rdst1;
  logic [4:0]  in_rdst2;
  logic [31:0] in_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        retire;
  logic        illegal_op;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(16), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rdst1   (in_rdst1),
    .in_rdst2   (in_rdst2),
    .in_result  (in_result),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .retire     (retire),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] res);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rdst1  = r1;
    in_rdst2  = r2;
    in_result = res;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_opcode = '0;
    in_rdst1  = '0;
    in_rdst2  = '0;
    in_result = '0;
  endtask

  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({rf_we, retire, illegal_op, busy} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got we/ret/ill/busy=%b want 0000", {rf_we, retire, illegal_op, busy}); end
    n_cmp++; if ({rf_waddr, rf_wdata} !== 21'd0) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h want 0/0", rf_waddr, rf_wdata); end
  endtask

  task automatic test_single();
    drive(6'b000001, 5'd3, 5'd0, 32'h0000_1234);
    step();
    idle_in();
    n_cmp++; if ({rf_we, busy} !== 2'b01) begin n_fail++; $display("FAIL add_lat: got we/busy=%b want 01", {rf_we, busy}); end
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd3, 16'h1234, 1'b1}) begin n_fail++; $display("FAIL add_write: got we=%b a=%0d d=%h ret=%b want 1/3/1234/1", rf_we, rf_waddr, rf_wdata, retire); end
    step();
    n_cmp++; if ({rf_we, retire, busy} !== 3'b000) begin n_fail++; $display("FAIL add_done: got we/ret/busy=%b want 000", {rf_we, retire, busy}); end
  endtask

  task automatic test_mul();
    drive(6'b000111, 5'd4, 5'd5, 32'hDEAD_BEEF);
    step();
    idle_in();
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd4, 16'hBEEF, 1'b0}) begin n_fail++; $display("FAIL mul_lo: got we=%b a=%0d d=%h ret=%b want 1/4/beef/0", rf_we, rf_waddr, rf_wdata, retire); end
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd5, 16'hDEAD, 1'b1}) begin n_fail++; $display("FAIL mul_hi: got we=%b a=%0d d=%h ret=%b want 1/5/dead/1", rf_we, rf_waddr, rf_wdata, retire); end
    step();
    n_cmp++; if ({rf_we, retire, busy} !== 3'b000) begin n_fail++; $display("FAIL mul_done: got we/ret/busy=%b want 000", {rf_we, retire, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy_seen;
    drive(6'b000111, 5'd4, 5'd5, 32'hDEAD_BEEF);
    step();
    rdy_seen[0] = in_ready;
    drive(6'b000010, 5'd7, 5'd0, 32'h0000_0042);
    step();
    rdy_seen[1] = in_ready;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 16'hBEEF}) begin n_fail++; $display("FAIL b2b_w0: got we=%b a=%0d d=%h want 1/4/beef", rf_we, rf_waddr, rf_wdata); end
    drive(6'b000001, 5'd8, 5'd0, 32'h0000_0077);
    step();
    rdy_seen[2] = in_ready;
    idle_in();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd5, 16'hDEAD, 1'b1}) begin n_fail++; $display("FAIL b2b_w1: got we=%b a=%0d d=%h ret=%b want 1/5/dead/1", rf_we, rf_waddr, rf_wdata, retire); end
    step();
    rdy_seen[3] = in_ready;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd7, 16'h0042, 1'b1}) begin n_fail++; $display("FAIL b2b_w2: got we=%b a=%0d d=%h ret=%b want 1/7/0042/1", rf_we, rf_waddr, rf_wdata, retire); end
    n_cmp++; if (rdy_seen !== 4'b1011) begin n_fail++; $display("FAIL b2b_ready: got seq(3..0)=%b want 1011", rdy_seen); end
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 16'h0077}) begin n_fail++; $display("FAIL b2b_w3: got we=%b a=%0d d=%h want 1/8/0077", rf_we, rf_waddr, rf_wdata); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_store_illegal();
    drive(6'b000011, 5'd9, 5'd0, 32'h0000_5555);
    step();
    drive(6'b111111, 5'd10, 5'd11, 32'h1234_5678);
    step();
    idle_in();
    n_cmp++; if ({rf_we, retire, illegal_op} !== 3'b010) begin n_fail++; $display("FAIL store_drop: got we/ret/ill=%b want 010", {rf_we, retire, illegal_op}); end
    step();
    n_cmp++; if ({rf_we, retire, illegal_op} !== 3'b011) begin n_fail++; $display("FAIL illegal_drop: got we/ret/ill=%b want 011", {rf_we, retire, illegal_op}); end
    step();
    n_cmp++; if ({rf_we, retire, illegal_op, busy} !== 4'b0000) begin n_fail++; $display("FAIL drop_done: got we/ret/ill/busy=%b want 0000", {rf_we, retire, illegal_op, busy}); end
  endtask

  task automatic test_fill_stream();
    logic [5:0]  f_op  [8];
    logic [4:0]  f_r1  [8];
    logic [4:0]  f_r2  [8];
    logic [31:0] f_res [8];
    logic [4:0]  e_addr[10];
    logic [15:0] e_data[10];
    int idx, wr, ret, lows, ills;
    logic pushed;
    f_op[0] = 6'b000001; f_r1[0] = 5'd1;  f_r2[0] = 5'd0; f_res[0] = 32'hFFFF_0011;
    f_op[1] = 6'b000111; f_r1[1] = 5'd2;  f_r2[1] = 5'd3; f_res[1] = 32'hAAAA_5555;
    f_op[2] = 6'b000010; f_r1[2] = 5'd4;  f_r2[2] = 5'd0; f_res[2] = 32'h0000_0044;
    f_op[3] = 6'b000111; f_r1[3] = 5'd5;  f_r2[3] = 5'd6; f_res[3] = 32'h1111_2222;
    f_op[4] = 6'b000111; f_r1[4] = 5'd7;  f_r2[4] = 5'd7; f_res[4] = 32'h3333_4444;
    f_op[5] = 6'b000001; f_r1[5] = 5'd8;  f_r2[5] = 5'd0; f_res[5] = 32'h0000_0088;
    f_op[6] = 6'b000011; f_r1[6] = 5'd9;  f_r2[6] = 5'd0; f_res[6] = 32'h0000_0099;
    f_op[7] = 6'b000001; f_r1[7] = 5'd10; f_r2[7] = 5'd0; f_res[7] = 32'h0000_00AA;
    e_addr[0] = 5'd1;  e_data[0] = 16'h0011;
    e_addr[1] = 5'd2;  e_data[1] = 16'h5555;
    e_addr[2] = 5'd3;  e_data[2] = 16'hAAAA;
    e_addr[3] = 5'd4;  e_data[3] = 16'h0044;
    e_addr[4] = 5'd5;  e_data[4] = 16'h2222;
    e_addr[5] = 5'd6;  e_data[5] = 16'h1111;
    e_addr[6] = 5'd7;  e_data[6] = 16'h4444;
    e_addr[7] = 5'd7;  e_data[7] = 16'h3333;
    e_addr[8] = 5'd8;  e_data[8] = 16'h0088;
    e_addr[9] = 5'd10; e_data[9] = 16'h00AA;
    idx = 0; wr = 0; ret = 0; lows = 0; ills = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx < 8) drive(f_op[idx], f_r1[idx], f_r2[idx], f_res[idx]);
      else idle_in();
      pushed = in_valid && in_ready;
      step();
      if (pushed) idx++;
      if (!in_ready) lows++;
      if (retire) ret++;
      if (illegal_op) ills++;
      if (rf_we) begin
        n_cmp++;
        if (wr >= 10) begin n_fail++; $display("FAIL fill_extra_write: got write #%0d a=%0d d=%h want none", wr, rf_waddr, rf_wdata); end
        else if ({rf_waddr, rf_wdata} !== {e_addr[wr], e_data[wr]}) begin n_fail++; $display("FAIL fill_write%0d: got a=%0d d=%h want a=%0d d=%h", wr, rf_waddr, rf_wdata, e_addr[wr], e_data[wr]); end
        wr++;
      end
    end
    n_cmp++; if (wr != 10) begin n_fail++; $display("FAIL fill_nwrites: got %0d want 10", wr); end
    n_cmp++; if (ret != 8) begin n_fail++; $display("FAIL fill_nretire: got %0d want 8", ret); end
    n_cmp++; if (lows != 3) begin n_fail++; $display("FAIL fill_ready_low: got %0d cycles want 3", lows); end
    n_cmp++; if (idx != 8 || ills != 0) begin n_fail++; $display("FAIL fill_pushed: got pushed=%0d ill=%0d want 8/0", idx, ills); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_mul();
    drive(6'b000111, 5'd12, 5'd13, 32'hCAFE_F00D);
    step();
    idle_in();
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 16'hF00D}) begin n_fail++; $display("FAIL rmid_lo: got we=%b a=%0d d=%h want 1/12/f00d", rf_we, rf_waddr, rf_wdata); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire, illegal_op, busy} !== 25'd0) begin n_fail++; $display("FAIL rmid_async: got we=%b a=%0d d=%h ret=%b ill=%b busy=%b want all 0", rf_we, rf_waddr, rf_wdata, retire, illegal_op, busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if ({rf_we, retire, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_quiet%0d: got we/ret/busy=%b want 000", k, {rf_we, retire, busy}); end
    end
    drive(6'b000001, 5'd14, 5'd0, 32'h0000_0BAD);
    step();
    idle_in();
    step();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd14, 16'h0BAD, 1'b1}) begin n_fail++; $display("FAIL rmid_after: got we=%b a=%0d d=%h ret=%b want 1/14/0bad/1", rf_we, rf_waddr, rf_wdata, retire); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_single();
    test_mul();
    test_back_to_back();
    test_store_illegal();
    test_fill_stream();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
